// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: post-reset drain, load-use stalls,
// ID-resolved branch flushes, data-memory waits with timeout, and saturating counters.
module pipe_hazard_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rsd_i,
    input  logic             ex_memread_i,
    input  logic             ex_valid_i,
    input  logic             branch_taken_i,
    input  logic             dmem_busy_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        init_cnt_q, init_cnt_d;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              stall_inc, flush_inc;
    logic              lu;
    logic              wait_expired;

    assign lu = ex_valid_i & ex_memread_i & (ex_rsd_i != 5'd0) &
                ((id_uses_rs1_i & (id_rs1_i == ex_rsd_i)) |
                 (id_uses_rs2_i & (id_rs2_i == ex_rsd_i)));

    // Widened by one bit so wait_cnt+1 cannot wrap before the comparison.
    assign wait_expired = (MEM_TIMEOUT != 0) &&
                          (({1'b0, wait_cnt_q} + 17'd1) >= 17'(MEM_TIMEOUT));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= 8'(INIT_CYCLES - 1);
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        err_o         = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        case (state_q)
            ST_INIT: begin
                ifid_write_o  = 1'b1;
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
                if (init_cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q - 8'd1;
                end
            end

            ST_RUN, ST_MEM_WAIT: begin
                if (dmem_busy_i) begin
                    pipe_hold_o = 1'b1;
                    if (state_q == ST_RUN) begin
                        wait_cnt_d = 16'd1;
                        state_d    = (MEM_TIMEOUT == 1) ? ST_ERR : ST_MEM_WAIT;
                    end else if (wait_expired) begin
                        state_d = ST_ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end else begin
                    // Memory ready: the normal hazard decision applies in this same cycle.
                    state_d    = ST_RUN;
                    wait_cnt_d = 16'd0;
                    if (lu) begin
                        idex_bubble_o = 1'b1;
                        stall_inc     = 1'b1;
                    end else if (branch_taken_i) begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                        ifid_flush_o = 1'b1;
                        flush_inc    = 1'b1;
                    end else begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                    end
                end
            end

            ST_ERR: begin
                pipe_hold_o = 1'b1;
                err_o       = 1'b1;
            end

            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
